scfifo_valid_model: RTL and testbench

//   Parametrised single-clock FIFO model with output-valid tracking. It is the successor to
//   the 1-bit dual-clock valid-tracking FIFO model, for single-domain paths.

---
 rtl/fifo_model_pkg.sv | 15 +
 rtl/fifo_ram_1w1r.sv | 31 +++
 rtl/scfifo_valid_model.sv | 102 ++++++++++
 tb/tb_scfifo_valid_model.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_model_pkg.sv
// Shared definitions for the FIFO model family: read-mode encodings and a
// clog2 helper that never returns zero, so every pointer is at least 1 bit wide.
package fifo_model_pkg;

  localparam int FIFO_MODE_NORMAL    = 0;
  localparam int FIFO_MODE_SHOWAHEAD = 1;

  function automatic int clog2_safe(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_ram_1w1r.sv
// Simple dual-port storage: one write port and one registered read port.
// Only the read register is cleared by aclr; the array itself carries no reset.
module fifo_ram_1w1r
  import fifo_model_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 128
) (
  input  logic                             clock,
  input  logic                             aclr,
  input  logic                             wr_en,
  input  logic [clog2_safe(DEPTH)-1:0]     wr_addr,
  input  logic [WIDTH-1:0]                 wr_data,
  input  logic                             rd_en,
  input  logic [clog2_safe(DEPTH)-1:0]     rd_addr,
  output logic [WIDTH-1:0]                 rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read-before-write on an address collision; the top level bypasses that case.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr)       rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/scfifo_valid_model.sv
// Single-clock FIFO model with q_valid tracking, usedw/almost_full and sticky
// overflow/underflow flags; normal (1-cycle latency) or show-ahead read mode.
module scfifo_valid_model
  import fifo_model_pkg::*;
#(
  parameter int WIDTH             = 8,
  parameter int DEPTH             = 128,
  parameter int SHOWAHEAD         = FIFO_MODE_NORMAL,
  parameter int ALMOST_FULL_VALUE = 96
) (
  input  logic                          clock,
  input  logic                          aclr,
  input  logic [WIDTH-1:0]              data,
  input  logic                          wrreq,
  input  logic                          rdreq,
  output logic [WIDTH-1:0]              q,
  output logic                          q_valid,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_full,
  output logic [clog2_safe(DEPTH):0]    usedw,
  output logic                          overflow_err,
  output logic                          underflow_err
);

  localparam int WIDTHU = clog2_safe(DEPTH);
  localparam int UW     = WIDTHU + 1;
  localparam bit SA     = (SHOWAHEAD == FIFO_MODE_SHOWAHEAD);
  localparam logic [UW-1:0] FULL_V = UW'(DEPTH);
  localparam logic [UW-1:0] AF_V   = UW'(ALMOST_FULL_VALUE);

  logic [WIDTHU-1:0] wr_ptr, rd_ptr, rd_ptr_inc, ram_rd_addr;
  logic [UW-1:0]     usedw_r, usedw_next;
  logic              empty_r, full_r, af_r, ovf_r, udf_r, qv_r, byp_r;
  logic [WIDTH-1:0]  byp_data, ram_q;
  logic              wr_acc, rd_acc, ram_rd_en, byp_next;

  always_comb begin
    wr_acc      = wrreq & ~full_r;
    rd_acc      = rdreq & ~empty_r;
    rd_ptr_inc  = rd_ptr + WIDTHU'(1);
    usedw_next  = usedw_r + UW'(wr_acc) - UW'(rd_acc);
    // Show-ahead keeps the RAM read register loaded with the next head word
    // every cycle, so it serves as the 1-entry output register.
    ram_rd_en   = SA ? 1'b1 : rd_acc;
    ram_rd_addr = (SA && rd_acc) ? rd_ptr_inc : rd_ptr;
    // The next head is being written this very edge (empty, or last word
    // popped alongside a write): the RAM read misses it, so capture data.
    byp_next    = SA && wr_acc && (wr_ptr == ram_rd_addr);
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      usedw_r  <= '0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      af_r     <= 1'b0;
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
      qv_r     <= 1'b0;
      byp_r    <= 1'b0;
      byp_data <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + WIDTHU'(1);
      if (rd_acc) rd_ptr <= rd_ptr_inc;
      usedw_r <= usedw_next;
      empty_r <= (usedw_next == '0);
      full_r  <= (usedw_next == FULL_V);
      af_r    <= (usedw_next >= AF_V);
      if (wrreq && full_r)  ovf_r <= 1'b1;
      if (rdreq && empty_r) udf_r <= 1'b1;
      qv_r    <= rd_acc;
      byp_r   <= byp_next;
      if (byp_next) byp_data <= data;
    end
  end

  fifo_ram_1w1r #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clock   (clock),
    .aclr    (aclr),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (data),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_q)
  );

  always_comb begin
    q             = (SA && byp_r) ? byp_data : ram_q;
    q_valid       = SA ? ~empty_r : qv_r;
    empty         = empty_r;
    full          = full_r;
    almost_full   = af_r;
    usedw         = usedw_r;
    overflow_err  = ovf_r;
    underflow_err = udf_r;
  end

endmodule

// File: tb/tb_scfifo_valid_model.sv
// Directed bench: a DEPTH=4 normal-mode instance and a DEPTH=4 show-ahead
// instance share clock and aclr; expected values are hand-computed constants.
module tb_scfifo_valid_model;

  logic       clock = 1'b0;
  logic       aclr  = 1'b1;

  logic [7:0] n_data = '0, s_data = '0;
  logic       n_wrreq = 1'b0, n_rdreq = 1'b0, s_wrreq = 1'b0, s_rdreq = 1'b0;
  logic [7:0] n_q, s_q;
  logic       n_qv, n_empty, n_full, n_af, n_ovf, n_udf;
  logic       s_qv, s_empty, s_full, s_af, s_ovf, s_udf;
  logic [2:0] n_usedw, s_usedw;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  scfifo_valid_model #(.WIDTH(8), .DEPTH(4), .SHOWAHEAD(0), .ALMOST_FULL_VALUE(3)) dut_n (
    .clock(clock), .aclr(aclr), .data(n_data), .wrreq(n_wrreq), .rdreq(n_rdreq),
    .q(n_q), .q_valid(n_qv), .empty(n_empty), .full(n_full), .almost_full(n_af),
    .usedw(n_usedw), .overflow_err(n_ovf), .underflow_err(n_udf)
  );

  scfifo_valid_model #(.WIDTH(8), .DEPTH(4), .SHOWAHEAD(1), .ALMOST_FULL_VALUE(3)) dut_s (
    .clock(clock), .aclr(aclr), .data(s_data), .wrreq(s_wrreq), .rdreq(s_rdreq),
    .q(s_q), .q_valid(s_qv), .empty(s_empty), .full(s_full), .almost_full(s_af),
    .usedw(s_usedw), .overflow_err(s_ovf), .underflow_err(s_udf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1 aclr = 1'b0;

    // reset state
    check("rst_empty", n_empty, 1);
    check("rst_usedw", n_usedw, 0);
    check("rst_q",     n_q,     0);
    check("rst_qv",    n_qv,    0);
    check("rst_full",  n_full,  0);
    check("rst_af",    n_af,    0);
    check("rst_s_qv",  s_qv,    0);

    // 1: normal mode write 3, read 3
    n_wrreq = 1'b1;
    n_data = 8'h11; step();
    n_data = 8'h22; step();
    n_data = 8'h33; step();
    n_wrreq = 1'b0;
    check("t1_usedw3", n_usedw, 3);
    check("t1_af",     n_af,    1);
    check("t1_qv_idle", n_qv,   0);
    n_rdreq = 1'b1;
    step(); check("t1_q0", n_q, 8'h11); check("t1_qv0", n_qv, 1); check("t1_u0", n_usedw, 2);
    step(); check("t1_q1", n_q, 8'h22); check("t1_qv1", n_qv, 1); check("t1_u1", n_usedw, 1);
    step(); check("t1_q2", n_q, 8'h33); check("t1_qv2", n_qv, 1); check("t1_u2", n_usedw, 0);
    check("t1_empty", n_empty, 1);
    n_rdreq = 1'b0;
    step(); check("t1_qv_off", n_qv, 0); check("t1_q_hold", n_q, 8'h33);
    check("t1_no_udf", n_udf, 0);

    // 2: fill to full, overflow, read back
    n_wrreq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_data = 8'(i); step();
    end
    check("t2_full", n_full, 1);
    check("t2_usedw4", n_usedw, 4);
    n_data = 8'h99; step();
    n_wrreq = 1'b0;
    check("t2_ovf", n_ovf, 1);
    check("t2_usedw_stay", n_usedw, 4);
    n_rdreq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2_rd_q", n_q, i);
      check("t2_rd_qv", n_qv, 1);
    end
    n_rdreq = 1'b0;
    check("t2_empty", n_empty, 1);

    // 3: underflow
    n_rdreq = 1'b1;
    step();
    n_rdreq = 1'b0;
    check("t3_udf", n_udf, 1);
    check("t3_qv", n_qv, 0);
    check("t3_usedw", n_usedw, 0);
    step(); step();
    check("t3_udf_sticky", n_udf, 1);
    check("t3_ovf_sticky", n_ovf, 1);

    // 4: simultaneous write+read at usedw=2 across pointer wrap
    n_wrreq = 1'b1;
    n_data = 8'hA0; step();
    n_data = 8'hA1; step();
    n_rdreq = 1'b1;
    for (int k = 0; k < 10; k++) begin
      n_data = 8'(8'hA2 + k);
      step();
      check("t4_usedw", n_usedw, 2);
      check("t4_q", n_q, 8'hA0 + k);
      check("t4_qv", n_qv, 1);
    end
    n_wrreq = 1'b0;
    step(); check("t4_drain0", n_q, 8'hAA);
    step(); check("t4_drain1", n_q, 8'hAB); check("t4_drain_empty", n_empty, 1);
    n_rdreq = 1'b0;

    // 5: show-ahead
    s_wrreq = 1'b1; s_data = 8'hA5;
    step();
    s_wrreq = 1'b0;
    check("t5_q", s_q, 8'hA5); check("t5_qv", s_qv, 1); check("t5_usedw", s_usedw, 1);
    step();
    check("t5_q_hold", s_q, 8'hA5); check("t5_qv_hold", s_qv, 1);
    s_rdreq = 1'b1; step(); s_rdreq = 1'b0;
    check("t5_empty", s_empty, 1); check("t5_qv_off", s_qv, 0);
    s_wrreq = 1'b1;
    s_data = 8'hB1; step();
    check("t5_b_first", s_q, 8'hB1);
    s_data = 8'hB2; step();
    s_data = 8'hB3; step();
    s_wrreq = 1'b0;
    check("t5_b_head", s_q, 8'hB1); check("t5_b_usedw", s_usedw, 3); check("t5_b_af", s_af, 1);
    s_rdreq = 1'b1;
    step(); check("t5_b2", s_q, 8'hB2); check("t5_b2_qv", s_qv, 1);
    step(); check("t5_b3", s_q, 8'hB3);
    step(); check("t5_b_empty", s_empty, 1); check("t5_b_qv", s_qv, 0);
    s_rdreq = 1'b0;
    s_wrreq = 1'b1; s_data = 8'hC1; step();
    s_rdreq = 1'b1; s_data = 8'hC2; step();
    s_wrreq = 1'b0;
    check("t5_c_q", s_q, 8'hC2); check("t5_c_qv", s_qv, 1); check("t5_c_usedw", s_usedw, 1);
    step(); s_rdreq = 1'b0;
    check("t5_c_empty", s_empty, 1);
    check("t5_no_err", {s_ovf, s_udf}, 0);

    // 6: aclr mid-burst with pending read
    n_wrreq = 1'b1;
    n_data = 8'hD0; step();
    n_data = 8'hD1; step();
    n_data = 8'hD2; step();
    n_wrreq = 1'b0;
    n_rdreq = 1'b1;
    step();
    check("t6_pre_q", n_q, 8'hD0);
    #2 aclr = 1'b1;
    #1;
    check("t6_usedw", n_usedw, 0);
    check("t6_empty", n_empty, 1);
    check("t6_q", n_q, 0);
    check("t6_qv", n_qv, 0);
    check("t6_flags", {n_full, n_af, n_ovf, n_udf}, 0);
    n_rdreq = 1'b0;
    step();
    aclr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_post_qv", n_qv, 0);
      check("t6_post_usedw", n_usedw, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
